// File: rtl/merlin_bus_arbiter.sv
// merlin_bus_arbiter: two-to-one arbiter that shares one in-order memory port
// between the instruction fetch bus and the load/store data bus. Requests and
// responses pass through combinationally. A small source FIFO remembers which
// requester issued each outstanding request, so every in-order response is
// returned to the requester that issued it.
module merlin_bus_arbiter #(
    parameter int unsigned C_MAX_OUTSTANDING_X = 2,
    parameter bit          C_ROUND_ROBIN       = 1'b0
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        clk_en_i,

    // instruction bus
    input  logic        ireqvalid_i,
    output logic        ireqready_o,
    input  logic [1:0]  ireqhpl_i,
    input  logic [31:0] ireqaddr_i,
    output logic        irspvalid_o,
    input  logic        irspready_i,
    output logic        irsprerr_o,
    output logic [31:0] irspdata_o,

    // data bus
    input  logic        dreqvalid_i,
    output logic        dreqready_o,
    input  logic [1:0]  dreqhpl_i,
    input  logic [31:0] dreqaddr_i,
    input  logic        dreqwr_i,
    input  logic [1:0]  dreqsize_i,
    input  logic [31:0] dreqdata_i,
    output logic        drspvalid_o,
    input  logic        drspready_i,
    output logic        drsprerr_o,
    output logic [31:0] drspdata_o,

    // memory bus
    output logic        mreqvalid_o,
    input  logic        mreqready_i,
    output logic [1:0]  mreqhpl_o,
    output logic [31:0] mreqaddr_o,
    output logic        mreqwr_o,
    output logic [1:0]  mreqsize_o,
    output logic [31:0] mreqdata_o,
    input  logic        mrspvalid_i,
    output logic        mrspready_o,
    input  logic        mrsprerr_i,
    input  logic [31:0] mrspdata_i
);

    localparam int unsigned PTR_W = C_MAX_OUTSTANDING_X;
    localparam int unsigned LVL_W = C_MAX_OUTSTANDING_X + 1;
    localparam int unsigned DEPTH = 1 << C_MAX_OUTSTANDING_X;

    typedef enum logic {
        SRC_INSTR = 1'b0,
        SRC_DATA  = 1'b1
    } src_e;

    // tracker: one bit per outstanding request, 1 = issued by the data bus
    logic [DEPTH-1:0] track_q, track_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [LVL_W-1:0] level_q, level_d;

    // arbitration history and stall hold
    src_e last_q, last_d;
    logic lock_q, lock_d;
    src_e lock_src_q, lock_src_d;

    logic space;
    logic empty;
    logic head;
    logic locked_valid;
    src_e grant;
    logic grant_valid;
    logic accept;
    logic stall;
    logic push;
    logic pop;

    // room for another outstanding request; a same-cycle pop does not count
    assign space = (level_q < LVL_W'(DEPTH));
    assign empty = (level_q == '0);
    assign head  = track_q[rptr_q];

    assign locked_valid = (lock_src_q == SRC_DATA) ? dreqvalid_i : ireqvalid_i;

    // request arbitration: locked source first, then single requester, then policy
    always_comb begin
        grant = SRC_DATA;
        if (lock_q && locked_valid) begin
            grant = lock_src_q;
        end else if (ireqvalid_i && !dreqvalid_i) begin
            grant = SRC_INSTR;
        end else if (dreqvalid_i && !ireqvalid_i) begin
            grant = SRC_DATA;
        end else if (ireqvalid_i && dreqvalid_i) begin
            if (C_ROUND_ROBIN && (last_q == SRC_DATA)) begin
                grant = SRC_INSTR;
            end else begin
                grant = SRC_DATA;
            end
        end
    end

    assign grant_valid = (grant == SRC_DATA) ? dreqvalid_i : ireqvalid_i;

    assign mreqvalid_o = space & grant_valid;
    assign ireqready_o = mreqready_i & space & (grant == SRC_INSTR);
    assign dreqready_o = mreqready_i & space & (grant == SRC_DATA);

    assign accept = mreqvalid_o & mreqready_i;
    assign stall  = mreqvalid_o & ~mreqready_i;

    // request payload mux; instruction fetches are always word loads
    always_comb begin
        if (grant == SRC_DATA) begin
            mreqhpl_o  = dreqhpl_i;
            mreqaddr_o = dreqaddr_i;
            mreqwr_o   = dreqwr_i;
            mreqsize_o = dreqsize_i;
            mreqdata_o = dreqdata_i;
        end else begin
            mreqhpl_o  = ireqhpl_i;
            mreqaddr_o = ireqaddr_i;
            mreqwr_o   = 1'b0;
            mreqsize_o = 2'b10;
            mreqdata_o = 32'h0;
        end
    end

    // response routing by tracker head; with an empty tracker responses are swallowed
    assign mrspready_o = empty | (head ? drspready_i : irspready_i);
    assign irspvalid_o = mrspvalid_i & ~empty & ~head;
    assign drspvalid_o = mrspvalid_i & ~empty & head;
    assign irsprerr_o  = mrsprerr_i;
    assign drsprerr_o  = mrsprerr_i;
    assign irspdata_o  = mrspdata_i;
    assign drspdata_o  = mrspdata_i;

    assign push = accept;
    assign pop  = mrspvalid_i & mrspready_o & ~empty;

    // next-state for tracker, arbitration history and stall lock
    always_comb begin
        track_d    = track_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        level_d    = level_q;
        last_d     = last_q;
        lock_d     = lock_q;
        lock_src_d = lock_src_q;

        if (push) begin
            track_d[wptr_q] = (grant == SRC_DATA);
            wptr_d          = wptr_q + PTR_W'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        if (accept) begin
            last_d = grant;
            lock_d = 1'b0;
        end else if (stall) begin
            lock_d     = 1'b1;
            lock_src_d = grant;
        end else if (lock_q && !locked_valid) begin
            lock_d = 1'b0;
        end
    end

    // state registers, frozen while clk_en_i is low
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            track_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            last_q     <= SRC_INSTR;
            lock_q     <= 1'b0;
            lock_src_q <= SRC_INSTR;
        end else if (clk_en_i) begin
            track_q    <= track_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            last_q     <= last_d;
            lock_q     <= lock_d;
            lock_src_q <= lock_src_d;
        end
    end

endmodule

// File: tb/tb_merlin_bus_arbiter.sv
// Directed bench for merlin_bus_arbiter: a fixed-priority instance and a
// round-robin instance share the same stimulus; each has its own outputs.
module tb_merlin_bus_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        clk_en_i;
    logic        ireqvalid_i, irspready_i;
    logic [1:0]  ireqhpl_i;
    logic [31:0] ireqaddr_i;
    logic        dreqvalid_i, dreqwr_i, drspready_i;
    logic [1:0]  dreqhpl_i, dreqsize_i;
    logic [31:0] dreqaddr_i, dreqdata_i;
    logic        mreqready_i, mrspvalid_i, mrsprerr_i;
    logic [31:0] mrspdata_i;

    // fixed-priority instance outputs
    logic        ireqready_o, irspvalid_o, irsprerr_o;
    logic [31:0] irspdata_o;
    logic        dreqready_o, drspvalid_o, drsprerr_o;
    logic [31:0] drspdata_o;
    logic        mreqvalid_o, mreqwr_o, mrspready_o;
    logic [1:0]  mreqhpl_o, mreqsize_o;
    logic [31:0] mreqaddr_o, mreqdata_o;

    // round-robin instance outputs
    logic        rr_ireqready, rr_irspvalid, rr_irsprerr;
    logic [31:0] rr_irspdata;
    logic        rr_dreqready, rr_drspvalid, rr_drsprerr;
    logic [31:0] rr_drspdata;
    logic        rr_mreqvalid, rr_mreqwr, rr_mrspready;
    logic [1:0]  rr_mreqhpl, rr_mreqsize;
    logic [31:0] rr_mreqaddr, rr_mreqdata;

    int n_checks = 0;
    int n_fail   = 0;

    merlin_bus_arbiter #(.C_MAX_OUTSTANDING_X(2), .C_ROUND_ROBIN(1'b0)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .clk_en_i(clk_en_i),
        .ireqvalid_i(ireqvalid_i), .ireqready_o(ireqready_o), .ireqhpl_i(ireqhpl_i),
        .ireqaddr_i(ireqaddr_i), .irspvalid_o(irspvalid_o), .irspready_i(irspready_i),
        .irsprerr_o(irsprerr_o), .irspdata_o(irspdata_o),
        .dreqvalid_i(dreqvalid_i), .dreqready_o(dreqready_o), .dreqhpl_i(dreqhpl_i),
        .dreqaddr_i(dreqaddr_i), .dreqwr_i(dreqwr_i), .dreqsize_i(dreqsize_i),
        .dreqdata_i(dreqdata_i), .drspvalid_o(drspvalid_o), .drspready_i(drspready_i),
        .drsprerr_o(drsprerr_o), .drspdata_o(drspdata_o),
        .mreqvalid_o(mreqvalid_o), .mreqready_i(mreqready_i), .mreqhpl_o(mreqhpl_o),
        .mreqaddr_o(mreqaddr_o), .mreqwr_o(mreqwr_o), .mreqsize_o(mreqsize_o),
        .mreqdata_o(mreqdata_o), .mrspvalid_i(mrspvalid_i), .mrspready_o(mrspready_o),
        .mrsprerr_i(mrsprerr_i), .mrspdata_i(mrspdata_i)
    );

    merlin_bus_arbiter #(.C_MAX_OUTSTANDING_X(2), .C_ROUND_ROBIN(1'b1)) dut_rr (
        .clk_i(clk_i), .reset_i(reset_i), .clk_en_i(clk_en_i),
        .ireqvalid_i(ireqvalid_i), .ireqready_o(rr_ireqready), .ireqhpl_i(ireqhpl_i),
        .ireqaddr_i(ireqaddr_i), .irspvalid_o(rr_irspvalid), .irspready_i(irspready_i),
        .irsprerr_o(rr_irsprerr), .irspdata_o(rr_irspdata),
        .dreqvalid_i(dreqvalid_i), .dreqready_o(rr_dreqready), .dreqhpl_i(dreqhpl_i),
        .dreqaddr_i(dreqaddr_i), .dreqwr_i(dreqwr_i), .dreqsize_i(dreqsize_i),
        .dreqdata_i(dreqdata_i), .drspvalid_o(rr_drspvalid), .drspready_i(drspready_i),
        .drsprerr_o(rr_drsprerr), .drspdata_o(rr_drspdata),
        .mreqvalid_o(rr_mreqvalid), .mreqready_i(mreqready_i), .mreqhpl_o(rr_mreqhpl),
        .mreqaddr_o(rr_mreqaddr), .mreqwr_o(rr_mreqwr), .mreqsize_o(rr_mreqsize),
        .mreqdata_o(rr_mreqdata), .mrspvalid_i(mrspvalid_i), .mrspready_o(rr_mrspready),
        .mrsprerr_i(mrsprerr_i), .mrspdata_i(mrspdata_i)
    );

    always #5 clk_i = ~clk_i;

    // compare one observed value with its expected value
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        clk_en_i    = 1'b1;
        ireqvalid_i = 1'b0; ireqhpl_i = 2'b00; ireqaddr_i = 32'h0;
        irspready_i = 1'b1;
        dreqvalid_i = 1'b0; dreqhpl_i = 2'b00; dreqaddr_i = 32'h0;
        dreqwr_i    = 1'b0; dreqsize_i = 2'b00; dreqdata_i = 32'h0;
        drspready_i = 1'b1;
        mreqready_i = 1'b1;
        mrspvalid_i = 1'b0; mrsprerr_i = 1'b0; mrspdata_i = 32'h0;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        idle_inputs();
        step();
        reset_i = 1'b0;
        #1;
    endtask

    initial begin
        idle_inputs();
        #2;
        reset_i = 1'b1;
        #1;
        // reset state
        check("rst_mreqvalid", 32'(mreqvalid_o), 32'd0);
        check("rst_irspvalid", 32'(irspvalid_o), 32'd0);
        check("rst_drspvalid", 32'(drspvalid_o), 32'd0);
        check("rst_mrspready", 32'(mrspready_o), 32'd1);
        do_reset();

        // instruction-only traffic, responses one cycle later
        ireqvalid_i = 1'b1; ireqaddr_i = 32'h0; ireqhpl_i = 2'b11;
        dreqdata_i = 32'hDEAD_BEEF; dreqwr_i = 1'b1; dreqsize_i = 2'b00;
        #1;
        check("i0_mreqvalid", 32'(mreqvalid_o), 32'd1);
        check("i0_mreqaddr", mreqaddr_o, 32'h0);
        check("i0_mreqsize", 32'(mreqsize_o), 32'd2);
        check("i0_mreqwr", 32'(mreqwr_o), 32'd0);
        check("i0_mreqdata", mreqdata_o, 32'h0);
        check("i0_mreqhpl", 32'(mreqhpl_o), 32'd3);
        check("i0_ireqready", 32'(ireqready_o), 32'd1);
        check("i0_dreqready", 32'(dreqready_o), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            step();
            ireqvalid_i = (k < 3);
            ireqaddr_i  = 32'(k * 4);
            mrspvalid_i = 1'b1;
            mrspdata_i  = 32'h1000_0000 + 32'(k);
            mrsprerr_i  = (k == 2);
            #1;
            check("i_irspvalid", 32'(irspvalid_o), 32'd1);
            check("i_irspdata", irspdata_o, 32'h1000_0000 + 32'(k));
            check("i_drspvalid", 32'(drspvalid_o), 32'd0);
            check("i_irsprerr", 32'(irsprerr_o), 32'(k == 2));
            check("i_drsprerr", 32'(drsprerr_o), 32'(k == 2));
            check("i_mreqvalid", 32'(mreqvalid_o), 32'(k < 3));
            if (k < 3) check("i_mreqaddr", mreqaddr_o, 32'(k * 4));
        end
        step();
        mrspvalid_i = 1'b0; mrsprerr_i = 1'b0;
        do_reset();

        // contention every cycle: fixed priority vs round robin
        ireqvalid_i = 1'b1; ireqaddr_i = 32'h40;
        dreqvalid_i = 1'b1; dreqaddr_i = 32'h80;
        dreqwr_i = 1'b1; dreqsize_i = 2'b01; dreqdata_i = 32'h0000_55AA;
        for (int k = 0; k < 4; k++) begin
            mrspvalid_i = (k > 0);
            #1;
            check("fp_dreqready", 32'(dreqready_o), 32'd1);
            check("fp_ireqready", 32'(ireqready_o), 32'd0);
            check("fp_mreqaddr", mreqaddr_o, 32'h80);
            check("fp_mreqwr", 32'(mreqwr_o), 32'd1);
            check("rr_dreqready", 32'(rr_dreqready), 32'((k % 2) == 0));
            check("rr_ireqready", 32'(rr_ireqready), 32'((k % 2) == 1));
            check("rr_mreqaddr", rr_mreqaddr, ((k % 2) == 0) ? 32'h80 : 32'h40);
            if (k > 0) begin
                check("fp_drspvalid", 32'(drspvalid_o), 32'd1);
                check("rr_drspvalid", 32'(rr_drspvalid), 32'(((k - 1) % 2) == 0));
                check("rr_irspvalid", 32'(rr_irspvalid), 32'(((k - 1) % 2) == 1));
            end
            step();
        end
        do_reset();

        // stall holds the grant even when round robin would switch
        dreqvalid_i = 1'b1; dreqaddr_i = 32'h1000;
        #1;
        check("st0_rr_dreqready", 32'(rr_dreqready), 32'd1);
        step();
        dreqaddr_i = 32'h2000; mreqready_i = 1'b0;
        #1;
        check("st1_rr_mreqvalid", 32'(rr_mreqvalid), 32'd1);
        check("st1_rr_dreqready", 32'(rr_dreqready), 32'd0);
        step();
        ireqvalid_i = 1'b1; ireqaddr_i = 32'h3000;
        for (int k = 0; k < 2; k++) begin
            #1;
            check("st_rr_mreqaddr", rr_mreqaddr, 32'h2000);
            check("st_rr_ireqready", 32'(rr_ireqready), 32'd0);
            step();
        end
        mreqready_i = 1'b1;
        #1;
        check("st4_rr_dreqready", 32'(rr_dreqready), 32'd1);
        check("st4_rr_mreqaddr", rr_mreqaddr, 32'h2000);
        step();
        #1;
        check("st5_rr_ireqready", 32'(rr_ireqready), 32'd1);
        check("st5_rr_mreqaddr", rr_mreqaddr, 32'h3000);
        check("st5_fp_mreqaddr", mreqaddr_o, 32'h2000);
        do_reset();

        // tracker fills at four outstanding requests
        ireqvalid_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            ireqaddr_i = 32'(k * 4);
            #1;
            check("full_ireqready", 32'(ireqready_o), 32'(k < 4));
            check("full_mreqvalid", 32'(mreqvalid_o), 32'(k < 4));
            check("full_dreqready", 32'(dreqready_o), 32'd0);
            step();
        end
        mrspvalid_i = 1'b1; mrspdata_i = 32'h77;
        #1;
        check("full_irspvalid", 32'(irspvalid_o), 32'd1);
        check("full_pop_nospace", 32'(mreqvalid_o), 32'd0);
        step();
        mrspvalid_i = 1'b0;
        #1;
        check("full_after_pop_mreqvalid", 32'(mreqvalid_o), 32'd1);
        check("full_after_pop_ireqready", 32'(ireqready_o), 32'd1);
        do_reset();

        // I, D, I ordering with a stalled data response, then reset mid-stall
        ireqvalid_i = 1'b1; ireqaddr_i = 32'h100;
        #1;
        check("ord0_ireqready", 32'(ireqready_o), 32'd1);
        step();
        ireqvalid_i = 1'b0; dreqvalid_i = 1'b1; dreqaddr_i = 32'h200;
        mrspvalid_i = 1'b1; mrspdata_i = 32'hA0;
        #1;
        check("ord1_irspvalid", 32'(irspvalid_o), 32'd1);
        check("ord1_drspvalid", 32'(drspvalid_o), 32'd0);
        check("ord1_dreqready", 32'(dreqready_o), 32'd1);
        step();
        dreqvalid_i = 1'b0; ireqvalid_i = 1'b1; ireqaddr_i = 32'h104;
        mrspdata_i = 32'hB0; drspready_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            check("ord_stall_drspvalid", 32'(drspvalid_o), 32'd1);
            check("ord_stall_irspvalid", 32'(irspvalid_o), 32'd0);
            check("ord_stall_mrspready", 32'(mrspready_o), 32'd0);
            check("ord_stall_drspdata", drspdata_o, 32'hB0);
            step();
            ireqvalid_i = 1'b0;
        end
        reset_i = 1'b1;
        #1;
        check("midrst_mrspready", 32'(mrspready_o), 32'd1);
        check("midrst_drspvalid", 32'(drspvalid_o), 32'd0);
        check("midrst_irspvalid", 32'(irspvalid_o), 32'd0);
        do_reset();
        mrspvalid_i = 1'b1; mrspdata_i = 32'hC0;
        #1;
        check("post_rst_irspvalid", 32'(irspvalid_o), 32'd0);
        check("post_rst_drspvalid", 32'(drspvalid_o), 32'd0);
        check("post_rst_mrspready", 32'(mrspready_o), 32'd1);
        do_reset();

        // clock enable low freezes the tracker
        clk_en_i = 1'b0; ireqvalid_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("cen_mreqvalid", 32'(mreqvalid_o), 32'd1);
            step();
        end
        clk_en_i = 1'b1; ireqvalid_i = 1'b0; mrspvalid_i = 1'b1;
        #1;
        check("cen_irspvalid", 32'(irspvalid_o), 32'd0);
        check("cen_mrspready", 32'(mrspready_o), 32'd1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/merlin_bus_arbiter.md
# merlin_bus_arbiter

Two-to-one memory port arbiter that shares a single in-order memory interface between the pre-fetch unit's instruction bus and the load/store unit's data bus. It sits between the core and the external memory port. It grants one request per cycle and records the source of every accepted request in an ordering tracker. It routes each in-order response back to the requester that issued it. Requests and responses pass through combinationally, so the arbiter adds zero cycles of latency.

## Interface
- C_MAX_OUTSTANDING_X, 2: tracker depth is 2^X accepted-but-unanswered requests.
- C_ROUND_ROBIN, 0: 0 = fixed priority (data over instruction); 1 = alternate on contention.

- clk_i  input  1  clock
- reset_i  input  1  reset, asynchronous, active-high
- clk_en_i  input  1  gates every state update
- ireqvalid_i / ireqready_o  in/out  1  instruction request handshake
- ireqhpl_i  input  2  instruction request privilege level
- ireqaddr_i  input  32  instruction word address; bits [1:0] are zero
- irspvalid_o / irspready_i  out/in  1  instruction response handshake
- irsprerr_o  output  1  instruction response error
- irspdata_o  output  32  instruction response data
- dreqvalid_i / dreqready_o  in/out  1  data request handshake
- dreqhpl_i  input  2  data request privilege level
- dreqaddr_i  input  32  data request address
- dreqwr_i  input  1  1 = store, 0 = load
- dreqsize_i  input  2  00 = byte, 01 = half, 10 = word
- dreqdata_i  input  32  store data
- drspvalid_o / drspready_i  out/in  1  data response handshake
- drsprerr_o  output  1  data response error
- drspdata_o  output  32  data response data
- mreqvalid_o / mreqready_i  out/in  1  memory request handshake
- mreqhpl_o  output  2  memory request privilege level
- mreqaddr_o  output  32  memory request address
- mreqwr_o  output  1  memory request write flag
- mreqsize_o  output  2  memory request size
- mreqdata_o  output  32  memory request write data
- mrspvalid_i / mrspready_o  in/out  1  memory response handshake
- mrsprerr_i  input  1  memory response error
- mrspdata_i  input  32  memory response data

## Operation
- State:
  - tracker FIFO: 1 bit per entry, 1 = data; write/read pointers of C_MAX_OUTSTANDING_X bits plus a level counter of C_MAX_OUTSTANDING_X+1 bits
  - last_q: last granted source
  - lock_q / lock_src_q: stall hold
- space = level < 2^X. The full test uses the registered level only; a pop in the same cycle does not free space.
- Grant, combinational:
  - if lock_q is set and the locked source still asserts valid, grant the locked source;
  - else if only one source is valid, grant that source;
  - else, when both are valid: data wins if C_ROUND_ROBIN=0; otherwise grant the source that is not last_q.
- mreqvalid_o = space & (granted source valid).
- Request fields are muxed from the granted source.
- Instruction grant forces mreqwr_o=0, mreqsize_o=10, mreqdata_o=0.
- ireqready_o = mreqready_i & space & grant==instr. dreqready_o is defined the same way for data.
- Accept (mreqvalid_o & mreqready_i):
  - push the source bit;
  - update last_q;
  - clear lock_q.
- Stall (mreqvalid_o & ~mreqready_i): set lock_q and lock_src_q. If the locked source drops valid, the lock is released combinationally and the grant is re-arbitrated.
- Response routing uses the tracker head:
  - mrspready_o = head ? drspready_i : irspready_i;
  - the selected rsp valid = mrspvalid_i; the other rsp valid = 0;
  - data and rerr are broadcast to both responders.
- Pop on mrspvalid_i & mrspready_o.
- Tracker empty: mrspready_o=1 and the response is discarded. No valid is raised and there is no pop.
- Push and pop in the same cycle: level is unchanged and both pointers advance. Pointers wrap modulo 2^X.

## Timing
- Reset values: level=0, pointers=0, last_q=instr, lock_q=0.
  - Resulting outputs: mreqvalid_o=0, irspvalid_o=0, drspvalid_o=0, mrspready_o=1.
  - Ready outputs follow mreqready_i.
- Request path: 0-cycle combinational. The response path is also 0-cycle combinational.
- A response may arrive in the cycle after its request is accepted, at the earliest.
- Deasserting clk_en_i freezes all state; combinational outputs still follow their inputs.
- Asserting reset_i mid-operation clears the tracker. Responses still in flight are then dropped through the empty-tracker rule.

## Test plan
- Instr-only traffic, memory ready always, 1-cycle response latency, addresses 0x0, 0x4, 0x8 -> three instr grants with mreqsize_o=10 and mreqwr_o=0; each irspvalid_o follows its request by 1 cycle; drspvalid_o stays 0.
- Both sources valid every cycle:
  - C_ROUND_ROBIN=0 -> every grant goes to data;
  - C_ROUND_ROBIN=1 -> grants alternate D, I, D, I (last_q=instr after reset).
- Data granted and mreqready_i low for 3 cycles while instr becomes valid -> grant stays with data until acceptance; instr is granted on the next cycle.
- X=2, no responses, 6 requests -> 4 accepted, then all ready outputs 0. A single response with head=instr raises irspvalid_o; a new request is accepted on the following cycle.
- Interleaved I, D, I accepted, memory returns 3 responses, drspready_i held low for 2 cycles -> the second response stalls with mrspready_o=0 and ordering is preserved; then reset mid-stall -> level=0, and a subsequent mrspvalid_i is discarded.
